// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-outstanding imem read feeding the IF/ID register.
// Optional misaligned-fetch trap enabled by defining INST_FETCH_ALIGN_CHK_EN.
module inst_fetch #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] pc_addr_i,
  input  logic                  pc_valid_i,
  output logic                  pc_ready_o,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rvalid_i,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  input  logic                  id_ready_i,
  input  logic                  flush_i,
  output logic                  if_valid_o,
  output logic [INST_WIDTH-1:0] if_inst_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [ADDR_WIDTH-1:0] if_pc_plus4_o,
  output logic                  if_fault_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRAIN,
    ST_HOLD
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  if_valid_q;
  logic [INST_WIDTH-1:0] if_inst_q;
  logic [ADDR_WIDTH-1:0] if_pc_q;
  logic [ADDR_WIDTH-1:0] if_pc_plus4_q;
  logic                  if_fault_q;

  logic can_accept;
  logic accept;
  logic misalign;

  // pc_ready is held low during reset even though the state already reads IDLE
  always_comb begin
    can_accept = rst_ni && !flush_i &&
                 ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && id_ready_i));
    accept     = can_accept && pc_valid_i;
  end

`ifdef INST_FETCH_ALIGN_CHK_EN
  assign misalign = (pc_addr_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign pc_ready_o  = can_accept;
  assign imem_req_o  = accept && !misalign;
  assign imem_addr_o = imem_req_o ? pc_addr_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      if_valid_q    <= 1'b0;
      if_inst_q     <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      if_fault_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (flush_i) begin
            state_q    <= ST_IDLE;
            if_valid_q <= 1'b0;
          end else if (accept && misalign) begin
            // trapped fetch never touches memory; decode sees a faulting bubble
            state_q       <= ST_HOLD;
            if_valid_q    <= 1'b1;
            if_fault_q    <= 1'b1;
            if_inst_q     <= '0;
            if_pc_q       <= pc_addr_i;
            if_pc_plus4_q <= pc_addr_i + ADDR_WIDTH'(4);
          end else if (accept) begin
            state_q    <= ST_WAIT;
            addr_q     <= pc_addr_i;
            if_valid_q <= 1'b0;
          end else if ((state_q == ST_HOLD) && id_ready_i) begin
            state_q    <= ST_IDLE;
            if_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (flush_i) begin
            state_q    <= imem_rvalid_i ? ST_IDLE : ST_DRAIN;
            if_valid_q <= 1'b0;
          end else if (imem_rvalid_i) begin
            state_q       <= ST_HOLD;
            if_valid_q    <= 1'b1;
            if_fault_q    <= 1'b0;
            if_inst_q     <= imem_rdata_i;
            if_pc_q       <= addr_q;
            if_pc_plus4_q <= addr_q + ADDR_WIDTH'(4);
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid_i) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_valid_o    = if_valid_q;
  assign if_inst_o     = if_inst_q;
  assign if_pc_o       = if_pc_q;
  assign if_pc_plus4_o = if_pc_plus4_q;
  assign if_fault_o    = if_fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: cycle vector table, corner sequences, then randomized
// traffic checked against an in-order address/instruction stream model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_fault;

  int n_pass  = 0;
  int n_total = 0;

  inst_fetch #(.INST_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pc_addr_i    (pc_addr),
    .pc_valid_i   (pc_valid),
    .pc_ready_o   (pc_ready),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_rvalid_i(imem_rvalid),
    .imem_rdata_i (imem_rdata),
    .id_ready_i   (id_ready),
    .flush_i      (flush),
    .if_valid_o   (if_valid),
    .if_inst_o    (if_inst),
    .if_pc_o      (if_pc),
    .if_pc_plus4_o(if_pc_plus4),
    .if_fault_o   (if_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic        pv;
    logic [31:0] pa;
    logic        rv;
    logic [31:0] rd;
    logic        idr;
    logic        fl;
    logic        e_prdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic pv, logic [31:0] pa, logic rv, logic [31:0] rd,
                              logic idr, logic fl, logic e_prdy, logic e_req,
                              logic [31:0] e_addr, logic e_ifv, logic [31:0] e_inst,
                              logic [31:0] e_pc, logic [31:0] e_pc4);
    vec_t v;
    v.pv = pv; v.pa = pa; v.rv = rv; v.rd = rd; v.idr = idr; v.fl = fl;
    v.e_prdy = e_prdy; v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv;
    v.e_inst = e_inst; v.e_pc = e_pc; v.e_pc4 = e_pc4;
    return v;
  endfunction

  // instruction memory contents as a pure function of the address
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic drive(logic pv, logic [31:0] pa, logic rv, logic [31:0] rd, logic idr, logic fl);
    pc_valid = pv; pc_addr = pa; imem_rvalid = rv; imem_rdata = rd; id_ready = idr; flush = fl;
  endtask

  localparam int N_RAND = 150;
  logic [31:0] addrs[N_RAND];

  initial begin
    int p_i, c_i, cyc, cnt;
    logic pending;
    logic [31:0] pend_addr;

    rst_n = 1'b0;
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);

    // reset holds everything quiet even with a valid pc
    repeat (3) @(negedge clk);
    #1;
    check("rst_pc_ready", pc_ready, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_inst", if_inst, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_pc_plus4", if_pc_plus4, 0);
    check("rst_if_fault", if_fault, 0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    //         pv  pa            rv  rd            idr fl   prdy req addr          ifv inst          pc            pc4
    vt.push_back(mk(1, 32'h0,        0, 32'h0,        0, 0,  1, 1, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        1, 32'h20080005, 0, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(1, 32'h4,      0, 32'h0,        0, 0,  0, 0, 32'h0,        1, 32'h20080005, 32'h0,        32'h4));
    vt.push_back(mk(1, 32'h4,        0, 32'h0,        1, 0,  1, 1, 32'h4,        1, 32'h20080005, 32'h0,        32'h4));
    vt.push_back(mk(0, 32'h0,        0, 32'h0,        1, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        1, 32'h8C090000, 1, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        0, 32'h0,        1, 0,  1, 0, 32'h0,        1, 32'h8C090000, 32'h4,        32'h8));
    vt.push_back(mk(1, 32'hFFFFFFFC, 0, 32'h0,        0, 0,  1, 1, 32'hFFFFFFFC, 0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        1, 32'h12345678, 0, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        0, 32'h0,        1, 0,  1, 0, 32'h0,        1, 32'h12345678, 32'hFFFFFFFC, 32'h0));
    // flush in WAIT, response three cycles after the request is drained
    vt.push_back(mk(1, 32'h10,       0, 32'h0,        0, 0,  1, 1, 32'h10,       0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(1, 32'h14,       0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(1, 32'h14,       0, 32'h0,        0, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(1, 32'h14,       1, 32'hDEADBEEF, 0, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        0, 32'h0,        1, 0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    // flush in HOLD
    vt.push_back(mk(1, 32'h20,       0, 32'h0,        0, 0,  1, 1, 32'h20,       0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        1, 32'h0000000A, 0, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(1, 32'h24,       0, 32'h0,        1, 1,  0, 0, 32'h0,        1, 32'h0000000A, 32'h20,       32'h24));
    vt.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    // flush in WAIT coincident with the response
    vt.push_back(mk(1, 32'h30,       0, 32'h0,        0, 0,  1, 1, 32'h30,       0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        1, 32'h0000000B, 0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    // flush in IDLE blocks the handshake; stray rvalid in IDLE is ignored
    vt.push_back(mk(1, 32'h40,       0, 32'h0,        0, 1,  0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        1, 32'h0000000C, 0, 0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    // back-to-back with k=1, stray rvalid in HOLD ignored
    vt.push_back(mk(1, 32'h50,       0, 32'h0,        1, 0,  1, 1, 32'h50,       0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(1, 32'h54,       1, 32'h50505050, 1, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(1, 32'h54,       0, 32'h0,        1, 0,  1, 1, 32'h54,       1, 32'h50505050, 32'h50,       32'h54));
    vt.push_back(mk(0, 32'h0,        1, 32'h54545454, 1, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,        1, 32'hFFFFFFFF, 0, 0,  0, 0, 32'h0,        1, 32'h54545454, 32'h54,       32'h58));
    vt.push_back(mk(0, 32'h0,        0, 32'h0,        1, 0,  1, 0, 32'h0,        1, 32'h54545454, 32'h54,       32'h58));
    vt.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0));

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].pv, vt[i].pa, vt[i].rv, vt[i].rd, vt[i].idr, vt[i].fl);
      #1;
      check($sformatf("vec%0d_pc_ready", i), pc_ready, vt[i].e_prdy);
      check($sformatf("vec%0d_imem_req", i), imem_req, vt[i].e_req);
      if (vt[i].e_req) check($sformatf("vec%0d_imem_addr", i), imem_addr, vt[i].e_addr);
      check($sformatf("vec%0d_if_valid", i), if_valid, vt[i].e_ifv);
      check($sformatf("vec%0d_if_fault", i), if_fault, 0);
      if (vt[i].e_ifv) begin
        check($sformatf("vec%0d_if_inst", i), if_inst, vt[i].e_inst);
        check($sformatf("vec%0d_if_pc", i), if_pc, vt[i].e_pc);
        check($sformatf("vec%0d_if_pc_plus4", i), if_pc_plus4, vt[i].e_pc4);
      end
    end

    // misaligned address
    @(negedge clk);
    drive(1'b1, 32'h6, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("mis_pc_ready", pc_ready, 1);
`ifdef INST_FETCH_ALIGN_CHK_EN
    check("mis_no_req", imem_req, 0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("mis_if_valid", if_valid, 1);
    check("mis_if_fault", if_fault, 1);
    check("mis_if_inst", if_inst, 0);
    check("mis_if_pc", if_pc, 32'h6);
`else
    check("mis_req", imem_req, 1);
    check("mis_addr", imem_addr, 32'h6);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h77, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    check("mis_if_valid", if_valid, 1);
    check("mis_if_fault", if_fault, 0);
    check("mis_if_inst", if_inst, 32'h77);
    check("mis_if_pc", if_pc, 32'h6);
`endif
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("mis_back_idle", if_valid, 0);

    // reset in WAIT; late response must be ignored
    @(negedge clk);
    drive(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstw_pc_ready", pc_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h99, 1'b0, 1'b0);
    #1;
    check("rstw_idle_ready", pc_ready, 1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("rstw_ignored", if_valid, 0);

    // randomized traffic: every offered address must come back once, in order
    for (int i = 0; i < N_RAND; i++) addrs[i] = $urandom & 32'hFFFF_FFFC;
    p_i = 0; c_i = 0; cyc = 0; pending = 1'b0; pend_addr = '0; cnt = 0;
    while (c_i < N_RAND && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      pc_valid = (p_i < N_RAND) && ($urandom_range(0, 3) != 0);
      pc_addr  = (p_i < N_RAND) ? addrs[p_i] : 32'h0;
      id_ready = ($urandom_range(0, 2) != 0);
      flush    = 1'b0;
      if (pending && cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pending) cnt--;
      end
      #1;
      check("rand_req_is_handshake", imem_req, pc_valid && pc_ready);
      if (imem_req) begin
        check("rand_single_outstanding", pending, 0);
        check("rand_req_addr", imem_addr, addrs[p_i]);
      end
      if (pc_valid && pc_ready) p_i++;
      if (if_valid && id_ready) begin
        if (c_i < N_RAND) begin
          check("rand_if_pc", if_pc, addrs[c_i]);
          check("rand_if_inst", if_inst, mem_word(addrs[c_i]));
          check("rand_if_pc_plus4", if_pc_plus4, addrs[c_i] + 32'd4);
        end
        c_i++;
      end
      if (imem_rvalid) pending = 1'b0;
      if (imem_req) begin
        pending   = 1'b1;
        pend_addr = imem_addr;
        cnt       = $urandom_range(0, 3);
      end
    end
    check("rand_all_delivered", c_i, N_RAND);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
